vga2_sdram_arb: RTL and testbench

//  Shares the single VGA-side SDRAM burst-read port between two requesters:
//  m0 = vga2_readmem pixel fetch (high priority), m1 = auxiliary reader (sprite/texture preload).

---
 rtl/vga2_sdram_arb.sv | 132 +++++++++++++
 tb/tb_vga2_sdram_arb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga2_sdram_arb.sv
// vga2_sdram_arb: arbitrates the single VGA-side SDRAM burst-read port between
// m0 (pixel fetch, high priority) and m1 (auxiliary reader). One burst is in
// flight at a time. Read data and completion are routed to the burst owner.
// A starvation counter forces m1 through after MAX_WAIT cycles. A watchdog
// aborts any burst that runs TIMEOUT cycles without sdram_complete.
module vga2_sdram_arb #(
    parameter int MAX_WAIT = 16,     // 1..255
    parameter int TIMEOUT  = 1023    // 1..4095
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        m0_request,
    input  logic [25:0] m0_address,
    output logic        m0_ready,
    output logic        m0_rvalid,
    output logic        m0_complete,

    input  logic        m1_request,
    input  logic [25:0] m1_address,
    output logic        m1_ready,
    output logic        m1_rvalid,
    output logic        m1_complete,

    output logic [25:0] m_raddress,
    output logic [31:0] m_rdata,

    output logic        sdram_request,
    input  logic        sdram_ready,
    output logic [25:0] sdram_address,
    input  logic        sdram_rvalid,
    input  logic [25:0] sdram_raddress,
    input  logic [31:0] sdram_rdata,
    input  logic        sdram_complete,

    output logic        arb_timeout
);

    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [7:0]  WAIT_LIM = 8'(MAX_WAIT);
    localparam logic [11:0] TMO_LIM  = 12'(TIMEOUT);

    state_t      state, state_nxt;
    logic        owner, owner_nxt;       // 0 = m0, 1 = m1
    logic [7:0]  wait_cnt, wait_nxt;
    logic [11:0] tmo_cnt, tmo_nxt;

    logic        sel_m1;                 // IDLE winner is m1
    logic        win_req;
    logic        grant;
    logic        timeout_hit;
    logic        burst_done;

    // Read data and its address are broadcast. Only rvalid and complete carry ownership.
    assign m_raddress = sdram_raddress;
    assign m_rdata    = sdram_rdata;

    // Winner selection. A starved m1 beats m0. Otherwise m0 has priority.
    always_comb begin
        sel_m1      = m1_request && ((wait_cnt == WAIT_LIM) || !m0_request);
        win_req     = sel_m1 ? m1_request : m0_request;
        grant       = reset && (state == IDLE) && win_req && sdram_ready;
        timeout_hit = (state == BURST) && (tmo_cnt == TMO_LIM) && !sdram_complete;
        burst_done  = (state == BURST) && (sdram_complete || timeout_hit);
    end

    // Next-state logic and output gating. IDLE outputs are forced low while
    // reset is asserted, so requests present during reset never leak out.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        tmo_nxt       = tmo_cnt;
        sdram_request = 1'b0;
        sdram_address = sel_m1 ? m1_address : m0_address;
        m0_ready      = 1'b0;
        m1_ready      = 1'b0;
        m0_rvalid     = 1'b0;
        m1_rvalid     = 1'b0;
        m0_complete   = 1'b0;
        m1_complete   = 1'b0;
        arb_timeout   = 1'b0;
        case (state)
            IDLE: begin
                sdram_request = reset && win_req;
                m0_ready      = reset && !sel_m1 && m0_request && sdram_ready;
                m1_ready      = reset && sel_m1 && sdram_ready;
                if (grant) begin
                    state_nxt = BURST;
                    owner_nxt = sel_m1;
                    tmo_nxt   = 12'd0;
                end
            end
            BURST: begin
                tmo_nxt     = tmo_cnt + 12'd1;
                m0_rvalid   = !owner && sdram_rvalid;
                m1_rvalid   =  owner && sdram_rvalid;
                m0_complete = !owner && burst_done;
                m1_complete =  owner && burst_done;
                arb_timeout = timeout_hit;
                if (burst_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Starvation counter. It counts every cycle m1 waits, including cycles
    // spent behind another burst. It saturates at the limit and clears on an m1 grant.
    always_comb begin
        wait_nxt = wait_cnt;
        if (grant && sel_m1)
            wait_nxt = 8'd0;
        else if (m1_request && (wait_cnt < WAIT_LIM))
            wait_nxt = wait_cnt + 8'd1;
    end

    // State, owner and counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            owner    <= 1'b0;
            wait_cnt <= 8'd0;
            tmo_cnt  <= 12'd0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            wait_cnt <= wait_nxt;
            tmo_cnt  <= tmo_nxt;
        end
    end

endmodule

// File: tb/tb_vga2_sdram_arb.sv
// tb_vga2_sdram_arb: directed bench for the two-master SDRAM read arbiter.
// Every forwarded read word is expected from a scoreboard of (owner, data)
// entries. An entry is queued when the bench drives sdram_rvalid for a burst
// it expects to be routed.
module tb_vga2_sdram_arb;

    localparam int MAX_WAIT = 16;
    localparam int TIMEOUT  = 1023;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_request, m1_request;
    logic [25:0] m0_address, m1_address;
    logic        m0_ready, m0_rvalid, m0_complete;
    logic        m1_ready, m1_rvalid, m1_complete;
    logic [25:0] m_raddress;
    logic [31:0] m_rdata;
    logic        sdram_request, sdram_ready;
    logic [25:0] sdram_address, sdram_raddress;
    logic        sdram_rvalid, sdram_complete;
    logic [31:0] sdram_rdata;
    logic        arb_timeout;

    typedef struct packed {
        logic        own;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    vga2_sdram_arb #(.MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .m0_request(m0_request), .m0_address(m0_address), .m0_ready(m0_ready),
        .m0_rvalid(m0_rvalid), .m0_complete(m0_complete),
        .m1_request(m1_request), .m1_address(m1_address), .m1_ready(m1_ready),
        .m1_rvalid(m1_rvalid), .m1_complete(m1_complete),
        .m_raddress(m_raddress), .m_rdata(m_rdata),
        .sdram_request(sdram_request), .sdram_ready(sdram_ready),
        .sdram_address(sdram_address), .sdram_rvalid(sdram_rvalid),
        .sdram_raddress(sdram_raddress), .sdram_rdata(sdram_rdata),
        .sdram_complete(sdram_complete), .arb_timeout(arb_timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic check_quiet(input string name);
        check(name, {24'd0, sdram_request, m0_ready, m1_ready, m0_rvalid, m1_rvalid,
                     m0_complete, m1_complete, arb_timeout}, 32'd0);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        m0_request = 0; m1_request = 0; sdram_ready = 0;
        sdram_rvalid = 0; sdram_complete = 0;
    endtask

    task automatic drive_word(input logic own, input logic [31:0] d, input logic [25:0] a);
        sdram_rvalid   = 1;
        sdram_rdata    = d;
        sdram_raddress = a;
        sb.push_back({own, d});
    endtask

    // Scoreboard monitor: every routed word must match the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        if (reset && (m0_rvalid || m1_rvalid)) begin
            check("rvalid_expected", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rv_m1", {31'd0, m1_rvalid}, {31'd0, e.own});
                check("rv_m0", {31'd0, m0_rvalid}, {31'd0, !e.own});
                check("rdata", m_rdata, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic early;
        // Reset with every input active: outputs must all be low.
        reset = 0;
        m0_request = 1; m1_request = 1;
        m0_address = 26'h0001000; m1_address = 26'h2000000;
        sdram_ready = 1; sdram_rvalid = 1; sdram_complete = 1;
        sdram_raddress = '0; sdram_rdata = '0;
        #2 check_quiet("reset_outputs");
        repeat (2) @(posedge clock);
        cyc(); clear_inputs(); reset = 1;
        #1 check_quiet("post_reset_idle");

        // 1. m0 alone, 8-word burst.
        cyc(); m0_request = 1; m0_address = 26'h0001000; sdram_ready = 1;
        #1 check("t1_req", sdram_request, 1);
        check("t1_addr", sdram_address, 26'h0001000);
        check("t1_m0_ready", m0_ready, 1);
        check("t1_m1_ready", m1_ready, 0);
        cyc(); m0_request = 0; sdram_ready = 0;
        #1 check("t1_burst_ready", m0_ready, 0);
        check("t1_burst_req", sdram_request, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(); drive_word(1'b0, 32'hA000_0000 + i, 26'h0001000 + 26'(i));
            #1 check("t1_m0_rvalid", m0_rvalid, 1);
            check("t1_m1_rvalid", m1_rvalid, 0);
            check("t1_raddr", m_raddress, 26'h0001000 + 26'(i));
            check("t1_no_cpl", m0_complete, 0);
        end
        cyc(); sdram_rvalid = 0; sdram_complete = 1;
        #1 check("t1_m0_cpl", m0_complete, 1);
        check("t1_m1_cpl", m1_complete, 0);
        cyc(); sdram_complete = 1; sdram_rvalid = 1;
        #1 check("t1_idle_rv_drop", m0_rvalid, 0);
        check("t1_idle_cpl_drop", m0_complete, 0);
        cyc(); clear_inputs();

        // 2. Both request: m0 first, m1 the cycle after m0 completes.
        cyc(); m0_request = 1; m0_address = 26'h0000400;
        m1_request = 1; m1_address = 26'h1234560; sdram_ready = 1;
        #1 check("t2_addr_m0", sdram_address, 26'h0000400);
        check("t2_m0_ready", m0_ready, 1);
        check("t2_m1_ready", m1_ready, 0);
        cyc(); m0_request = 0;
        #1 check("t2_burst_m1_ready", m1_ready, 0);
        check("t2_burst_req", sdram_request, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(); drive_word(1'b0, 32'hB000_0000 + i, 26'h0000400 + 26'(i));
        end
        cyc(); sdram_rvalid = 0; sdram_complete = 1;
        #1 check("t2_m0_cpl", m0_complete, 1);
        check("t2_cpl_m1_ready", m1_ready, 0);
        check("t2_cpl_req", sdram_request, 0);
        cyc(); sdram_complete = 0;
        #1 check("t2_m1_req", sdram_request, 1);
        check("t2_addr_m1", sdram_address, 26'h1234560);
        check("t2_m1_ready", m1_ready, 1);
        check("t2_m0_ready", m0_ready, 0);
        cyc(); m1_request = 0; drive_word(1'b1, 32'hC0DE_0001, 26'h1234560);
        #1 check("t2_m1_rvalid", m1_rvalid, 1);
        check("t2_m0_rvalid", m0_rvalid, 0);
        cyc(); sdram_rvalid = 0; sdram_complete = 1;
        #1 check("t2_m1_cpl", m1_complete, 1);
        check("t2_m0_cpl_low", m0_complete, 0);
        cyc(); clear_inputs();

        // 6. sdram_ready held low for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            cyc(); m0_request = 1; m0_address = 26'h3ABCDE0; sdram_ready = 0;
            #1 check("t6_stall_req", sdram_request, 1);
            check("t6_stall_addr", sdram_address, 26'h3ABCDE0);
            check("t6_stall_ready", m0_ready, 0);
        end
        cyc(); sdram_ready = 1;
        #1 check("t6_ready", m0_ready, 1);
        check("t6_addr", sdram_address, 26'h3ABCDE0);
        cyc(); m0_request = 0; sdram_ready = 0; sdram_complete = 1;
        #1 check("t6_cpl", m0_complete, 1);
        cyc(); clear_inputs();

        // 5. Reset mid-burst.
        cyc(); m0_request = 1; m0_address = 26'h0000800; sdram_ready = 1;
        #1 check("t5_ready", m0_ready, 1);
        cyc(); m0_request = 0; sdram_ready = 0; drive_word(1'b0, 32'hD00D_0000, 26'h0000800);
        #1 check("t5_rvalid", m0_rvalid, 1);
        cyc(); reset = 0; sdram_rvalid = 1; sdram_complete = 1; m0_request = 1;
        #1 check_quiet("t5_reset_outputs");
        cyc(); reset = 1; m0_request = 0; sdram_complete = 0; sdram_rvalid = 1;
        #1 check("t5_rv_drop_m0", m0_rvalid, 0);
        check("t5_rv_drop_m1", m1_rvalid, 0);
        cyc();
        #1 check("t5_rv_drop2", m0_rvalid, 0);
        cyc(); clear_inputs();

        // 3. Starvation: m0 back-to-back 2-cycle bursts, m1 held high.
        for (int k = 0; k <= MAX_WAIT; k++) begin
            cyc(); m0_request = 1; m1_request = 1; sdram_ready = 1;
            sdram_complete = k[0];
            #1;
            if (k == MAX_WAIT) begin
                check("t3_m1_grant", m1_ready, 1);
                check("t3_m0_blocked", m0_ready, 0);
                check("t3_wait_sat", dut.wait_cnt, 8'(MAX_WAIT));
            end else if (!k[0]) begin
                check("t3_m0_grant", m0_ready, 1);
                check("t3_m1_wait", m1_ready, 0);
            end else begin
                check("t3_m0_cpl", m0_complete, 1);
            end
        end
        cyc(); m0_request = 0; m1_request = 0; sdram_ready = 0; sdram_complete = 1;
        #1 check("t3_m1_cpl", m1_complete, 1);
        check("t3_wait_clear", dut.wait_cnt, 8'd0);
        cyc(); clear_inputs();

        // 4. Watchdog: m1 owns a burst that never completes.
        cyc(); m1_request = 1; m1_address = 26'h0FF0000; sdram_ready = 1;
        #1 check("t4_m1_ready", m1_ready, 1);
        early = 0;
        for (int i = 0; i <= TIMEOUT; i++) begin
            cyc(); m1_request = 0; sdram_ready = 0;
            #1;
            if (i < TIMEOUT) early = early | arb_timeout | m1_complete;
            else begin
                check("t4_timeout", arb_timeout, 1);
                check("t4_m1_cpl", m1_complete, 1);
                check("t4_m0_cpl", m0_complete, 0);
            end
        end
        check("t4_no_early", early, 0);
        cyc(); m0_request = 1; m0_address = 26'h0000010; sdram_ready = 1;
        #1 check("t4_idle_grant", m0_ready, 1);
        check("t4_pulse_once", arb_timeout, 0);
        cyc(); m0_request = 0; sdram_ready = 0; sdram_complete = 1;
        #1 check("t4_m0_cpl", m0_complete, 1);
        cyc(); clear_inputs();
        #1 check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
